// File: rtl/fx_square.sv
// fx_square: sequential radix-2 squarer for signed Q16.48 operands; result is |v|^2, saturated to the Q16.48 maximum.
// Latency: valid pulses in the cycle after the 65th edge following the accept edge (WIDTH+1 edges); one result per WIDTH+2 cycles.
// Backpressure: none; start is taken only when busy=0, and start while busy is dropped. Optional rounding: FX_SQUARE_ROUND_EN.
module fx_square #(
  parameter int WIDTH = 64,
  parameter int FRAC  = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] v,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;      // multiplier copy, consumed LSB first
  logic [PW-1:0]    mag_sh_q, mag_sh_d;  // mag << cnt, kept pre-shifted
  logic [PW-1:0]    acc_q, acc_d;        // full-width product, never truncated
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] mag_in;
  logic [PW:0]      acc_rnd;
  logic [PW:0]      prod;
  logic             sat;

  // Magnitude of the operand as unsigned; the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    mag_in = v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  end

  // Scale the finished product back to Q16.48, optionally rounding half up first, and detect saturation.
  always_comb begin
    acc_rnd = {1'b0, acc_q};
`ifdef FX_SQUARE_ROUND_EN
    acc_rnd = acc_rnd + ({{PW{1'b0}}, 1'b1} << (FRAC - 1));
`endif
    prod = acc_rnd >> FRAC;
    sat  = |prod[PW:WIDTH-1];
  end

  // Next-state logic for the IDLE/CALC/FIN sequencer and its datapath.
  always_comb begin
    state_d  = state_q;
    mplr_d   = mplr_q;
    mag_sh_d = mag_sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    res_d    = res_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mplr_d   = mag_in;
          mag_sh_d = {{WIDTH{1'b0}}, mag_in};
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (mplr_q[0]) begin
          acc_d = acc_q + mag_sh_q;
        end
        mplr_d   = mplr_q >> 1;
        mag_sh_d = mag_sh_q << 1;
        cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (sat) begin
          res_d = {1'b0, {(WIDTH-1){1'b1}}};
          ovf_d = 1'b1;
        end else begin
          res_d = prod[WIDTH-1:0];
          ovf_d = 1'b0;
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state registers, with synchronous active-low reset that abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mplr_q   <= '0;
      mag_sh_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mplr_q   <= mplr_d;
      mag_sh_q <= mag_sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign res   = res_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_fx_square.sv
// Scoreboarded bench for fx_square: directed vectors push expected results, a monitor pops on valid.
// Latency is measured from the accept edge; back-to-back spacing and single-cycle valid are tracked.
// Reset mid-operation must suppress the abandoned result.
module tb_fx_square;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] v;
  logic        busy;
  logic        valid;
  logic [63:0] res;
  logic        ovf;

  fx_square #(.WIDTH(64), .FRAC(48)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .v     (v),
    .busy  (busy),
    .valid (valid),
    .res   (res),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;
  bit   b2b_mode = 0;
  logic prev_valid = 1'b0;

  localparam logic [63:0] SAT = 64'h7FFF_FFFF_FFFF_FFFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Cycle counter and accept-edge recorder (inputs are stable at the rising edge).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) acc_cyc_q.delete();
    else if (start && !busy) acc_cyc_q.push_back(cyc);
  end

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      exp_t e;
      int   a;
      check("valid_single_cycle", {63'd0, prev_valid}, 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got res 0x%016h with no pending request", res);
      end else begin
        e = exp_q.pop_front();
        check("res", res, e.res);
        check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
      end
      if (acc_cyc_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL latency: got valid with no recorded accept, expected an accept 65 edges earlier");
      end else begin
        a = acc_cyc_q.pop_front();
        check("latency", 64'(cyc - a), 64'd65);
      end
      if (b2b_mode && last_valid_cyc != 0)
        check("b2b_period", 64'(cyc - last_valid_cyc), 64'd66);
      last_valid_cyc = cyc;
    end
    prev_valid = valid;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy still 1 after 200 cycles, expected 0");
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d results pending after 200 cycles, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [63:0] val, input logic [63:0] eres, input logic eovf);
    exp_t e;
    wait_idle();
    e.res = eres;
    e.ovf = eovf;
    exp_q.push_back(e);
    start = 1'b1;
    v     = val;
    @(negedge clk);
    start = 1'b0;
    v     = 64'h0123_4567_89AB_CDEF;  // later changes to v must not matter
    wait_empty();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   nv;
    int   n;
    rst_n = 1'b0;
    start = 1'b0;
    v     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy",  {63'd0, busy},  64'd0);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_res",   res,            64'd0);
    check("rst_ovf",   {63'd0, ovf},   64'd0);

    run_op(64'h0002_0000_0000_0000, 64'h0004_0000_0000_0000, 1'b0);  // 2.0
    run_op(64'h0000_8000_0000_0000, 64'h0000_4000_0000_0000, 1'b0);  // 0.5
    run_op(64'hFFFD_0000_0000_0000, 64'h0009_0000_0000_0000, 1'b0);  // -3.0
    run_op(64'h00B5_0000_0000_0000, 64'h7FF9_0000_0000_0000, 1'b0);  // 181.0
    run_op(64'h00B6_0000_0000_0000, SAT, 1'b1);                      // 182.0
    run_op(64'h8000_0000_0000_0000, SAT, 1'b1);                      // most negative
`ifdef FX_SQUARE_ROUND_EN
    run_op(64'h0000_0000_00C0_0000, 64'h1, 1'b0);
`else
    run_op(64'h0000_0000_00C0_0000, 64'h0, 1'b0);
`endif
    run_op(64'h0000_0000_0180_0000, 64'h2, 1'b0);

    // Second start while busy is ignored.
    wait_idle();
    e.res = 64'h0004_0000_0000_0000;
    e.ovf = 1'b0;
    exp_q.push_back(e);
    start = 1'b1;
    v     = 64'h0002_0000_0000_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    v     = 64'hFFFD_0000_0000_0000;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (80) @(negedge clk);

    // start held high: back-to-back results; the 4th accept lands in a valid cycle.
    b2b_mode       = 1;
    last_valid_cyc = 0;
    wait_idle();
    e.res = 64'h0000_4000_0000_0000;
    e.ovf = 1'b0;
    repeat (4) exp_q.push_back(e);
    start = 1'b1;
    v     = 64'h0000_8000_0000_0000;
    nv    = 0;
    n     = 0;
    while (nv < 3 && n < 400) begin
      @(negedge clk);
      if (valid) nv++;
      n++;
    end
    check("b2b_valid_count", 64'(nv), 64'd3);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_after_valid", {63'd0, busy}, 64'd1);
    wait_empty();
    b2b_mode = 0;

    // Reset 30 edges into an operation: result is abandoned.
    wait_idle();
    start = 1'b1;
    v     = 64'h0002_0000_0000_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy",  {63'd0, busy},  64'd0);
    check("midrst_res",   res,            64'd0);
    check("midrst_ovf",   {63'd0, ovf},   64'd0);
    check("midrst_valid", {63'd0, valid}, 64'd0);
    repeat (80) @(negedge clk);
    run_op(64'h0000_8000_0000_0000, 64'h0000_4000_0000_0000, 1'b0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fx_square.md
Name: fx_square

Overview:
- Sequential fixed-point squarer for the datapath's signed Q16.48 format: 1 sign bit, 15 integer bits, 48 fractional bits.
- It is the inverse of the square-root unit and is used to re-square lengths and distances, for example in sqrt round-trip checks and squared-norm compares.
- Radix-2 shift-add over |v|; one operand bit per cycle; start/busy/valid handshake.

Parameters:
- WIDTH, 64, total operand/result width in bits, including the sign bit.
- FRAC, 48, number of fractional bits; the result is the full product shifted right by FRAC.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request; accepted only when busy=0.
- v  input  WIDTH  signed Q16.48 operand; sampled only in the accept cycle.
- busy  output  1  high while an operation is in flight.
- valid  output  1  one-cycle pulse when res/ovf are updated.
- res  output  WIDTH  Q16.48 result, always >= 0; holds until the next valid.
- ovf  output  1  set when res saturated; updates only with valid.

Behaviour:
- Reset, applied when rst_n=0 at a clk edge:
  - state=IDLE; busy=0, valid=0, res=0, ovf=0.
  - Internal accumulator and counter cleared.
  - Any in-flight operation is abandoned; no valid is produced for it.
- States: IDLE, CALC, FIN.
- IDLE:
  - If start=1 at edge N: latch mag=|v| as a WIDTH-bit unsigned value. v=-2^63 gives mag=2^63.
  - At the same edge: multiplier copy := mag, acc(2*WIDTH bits) := 0, cnt := 0, busy := 1, state := CALC.
- CALC, one step per edge N+1 .. N+WIDTH:
  - If the current multiplier bit is 1, add (mag << cnt) to acc.
  - Increment cnt.
  - After the step at cnt=WIDTH-1, state := FIN.
- FIN, edge N+WIDTH+1:
  - p := acc >> FRAC.
  - If p > 2^(WIDTH-1)-1: res := 2^(WIDTH-1)-1 (0x7FFF_FFFF_FFFF_FFFF) and ovf := 1. Otherwise res := p[WIDTH-1:0] and ovf := 0.
  - valid := 1, busy := 0, state := IDLE.
- Latency: valid is high in the cycle after edge N+WIDTH+1, i.e. 65 edges after the accept edge at the defaults.
- Throughput: one result per WIDTH+2 cycles.
- valid is high for exactly one cycle.
- start while busy=1 is ignored; no queuing.
- start=1 in the same cycle as valid=1: accepted (state is IDLE), and busy rises on the next edge.
- v changing after the accept edge has no effect.
- Non-overflow input range: |v| <= about 181.02. Inputs at or below 181.0 never saturate.
- Arithmetic is unsigned on the magnitude. The result sign is always 0.
- No truncation of acc before FIN; the full 2*WIDTH-bit product is kept.

Optional Feature:
- Macro: FX_SQUARE_ROUND_EN.
- Defined: in FIN, p := (acc + 2^(FRAC-1)) >> FRAC (round half up). The saturation check is applied after rounding.
- Undefined: p := acc >> FRAC (truncation toward zero).
- Latency, handshake and ports are identical in both builds.

Test Plan:
- Positive values:
  - v=0x0002_0000_0000_0000 (2.0) -> res=0x0004_0000_0000_0000, ovf=0, valid exactly 65 edges after accept.
  - v=0x0000_8000_0000_0000 (0.5) -> res=0x0000_4000_0000_0000, ovf=0.
- Negative, boundary and saturation:
  - v=-3.0 (0xFFFD_0000_0000_0000) -> res=0x0009_0000_0000_0000.
  - v=0x00B5_0000_0000_0000 (181.0) -> res=0x7FF9_0000_0000_0000, ovf=0.
  - v=0x00B6_0000_0000_0000 (182.0) -> res=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
  - v=0x8000_0000_0000_0000 -> saturated, ovf=1.
- Rounding:
  - v=0x0000_0000_00C0_0000 -> res=0x0 without FX_SQUARE_ROUND_EN, 0x1 with it.
  - v=0x0000_0000_0180_0000 -> res=0x2 in both builds.
- Handshake:
  - Pulse start again at edge N+10 with a different v -> ignored; the first result is unchanged.
  - Hold start=1 continuously -> back-to-back results every 66 cycles; valid never high for two consecutive cycles.
- Reset mid-op:
  - Accept v=2.0, drive rst_n=0 at edge N+30 for one cycle.
  - Expect busy=0, res=0, ovf=0 and no valid.
  - A new start afterwards with v=0.5 yields 0x0000_4000_0000_0000 with normal latency.
